and_gate_unit: RTL and testbench

- Parameterised bitwise two-input AND element with a combinational result and a registered, valid-qualified copy.
- Used as a leaf logic primitive wherever a gated or combined enable or mask is needed.
- The combinational path must settle well within one stimulus step.
- The registered path gives a clean, timing-closed output with status flags.

---
 rtl/and_gate_pkg.sv | 17 +
 rtl/and_gate_unit_if.sv | 42 ++++
 rtl/and_gate_stats.sv | 35 +++
 rtl/and_gate_unit.sv | 51 +++++
 tb/tb_and_gate_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and types for the and_gate_unit slice.
// The optional statistics bank is built only when AND_GATE_STATS_EN is defined.
package and_gate_pkg;

    localparam int unsigned STAT_W    = 16;
    localparam int unsigned NUM_COMBO = 4;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    // Input combination {a[0], b[0]} seen on a valid cycle
    typedef enum logic [1:0] {
        C00 = 2'b00,
        C01 = 2'b01,
        C10 = 2'b10,
        C11 = 2'b11
    } combo_e;

endpackage

// File: rtl/and_gate_unit_if.sv
// Operand/result bundle for and_gate_unit.
// Statistics signals exist only when AND_GATE_STATS_EN is defined.
interface and_gate_unit_if #(
    parameter int unsigned WIDTH = 1
);
    import and_gate_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic             all_ones;
    logic             none_set;
`ifdef AND_GATE_STATS_EN
    logic              stat_clr;
    logic [1:0]        stat_sel;
    logic [STAT_W-1:0] stat_cnt;
`endif

`ifdef AND_GATE_STATS_EN
    modport master (
        output a, b, in_valid, stat_clr, stat_sel,
        input  y, y_q, out_valid, all_ones, none_set, stat_cnt
    );
    modport slave (
        input  a, b, in_valid, stat_clr, stat_sel,
        output y, y_q, out_valid, all_ones, none_set, stat_cnt
    );
`else
    modport master (
        output a, b, in_valid,
        input  y, y_q, out_valid, all_ones, none_set
    );
    modport slave (
        input  a, b, in_valid,
        output y, y_q, out_valid, all_ones, none_set
    );
`endif

endinterface

// File: rtl/and_gate_stats.sv
// Saturating per-combination counters of {a[0], b[0]} on valid cycles.
// Instantiated by and_gate_unit only when AND_GATE_STATS_EN is defined.
module and_gate_stats
    import and_gate_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stat_clr,
    input  logic              in_valid,
    input  logic              a0,
    input  logic              b0,
    input  logic [1:0]        stat_sel,
    output logic [STAT_W-1:0] stat_cnt
);

    logic [STAT_W-1:0] cnt [NUM_COMBO];
    combo_e            combo;

    assign combo = combo_e'({a0, b0});

    // Clear beats increment; counters stick at STAT_MAX instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < int'(NUM_COMBO); i++) begin
                cnt[i] <= '0;
            end
        end else if (in_valid && (cnt[combo] != STAT_MAX)) begin
            cnt[combo] <= cnt[combo] + STAT_W'(1);
        end
    end

    // Combinational read returns the value before any same-cycle increment
    assign stat_cnt = cnt[stat_sel];

endmodule

// File: rtl/and_gate_unit.sv
// Bitwise AND with a combinational result and a registered, valid-qualified
// copy plus all-ones / none-set flags.
// Optional per-combination statistics when AND_GATE_STATS_EN is defined.
module and_gate_unit
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input logic           clk,
    input logic           rst,
    and_gate_unit_if.slave bus
);

    logic [WIDTH-1:0] y_q_r;
    logic             out_valid_r;

    // Zero-latency path, independent of reset and valid
    assign bus.y = bus.a & bus.b;

    // Capture on valid; reset wins over a same-edge valid
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            y_q_r       <= bus.a & bus.b;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.y_q       = y_q_r;
    assign bus.out_valid = out_valid_r;
    assign bus.all_ones  = out_valid_r & (&y_q_r);
    assign bus.none_set  = out_valid_r & ~(|y_q_r);

`ifdef AND_GATE_STATS_EN
    and_gate_stats u_stats (
        .clk      (clk),
        .rst      (rst),
        .stat_clr (bus.stat_clr),
        .in_valid (bus.in_valid),
        .a0       (bus.a[0]),
        .b0       (bus.b[0]),
        .stat_sel (bus.stat_sel),
        .stat_cnt (bus.stat_cnt)
    );
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// Self-checking bench for and_gate_unit (WIDTH=1 and WIDTH=8 instances).
// Statistics scenarios are compiled in when AND_GATE_STATS_EN is defined.
module tb_and_gate_unit;

    typedef struct packed {
        logic [7:0] yq;
        logic       ov;
        logic       ao;
        logic       ns;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exp_t       exp_q [$];
    logic [7:0] m_yq;
    logic       m_ov;

    and_gate_unit_if #(.WIDTH(1)) if1 ();
    and_gate_unit_if #(.WIDTH(8)) if8 ();

    and_gate_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    and_gate_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle on the 8-bit instance and push the model's expectation
    task automatic cycle8(input logic [7:0] a, input logic [7:0] b,
                          input logic v, input logic r);
        @(negedge clk);
        if8.a        = a;
        if8.b        = b;
        if8.in_valid = v;
        rst          = r;
        if (r) begin
            m_yq = 8'h00;
            m_ov = 1'b0;
        end else if (v) begin
            m_yq = a & b;
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        exp_q.push_back('{m_yq, m_ov, m_ov && (m_yq == 8'hFF), m_ov && (m_yq == 8'h00)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            cycle8(8'hFF, 8'hFF, 1'b1, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== {e.yq, e.ov, e.ao, e.ns}) begin
                n_fail++;
                $display("FAIL reset8: got yq=%h ov=%b ao=%b ns=%b, expected yq=%h ov=%b ao=%b ns=%b",
                         if8.y_q, if8.out_valid, if8.all_ones, if8.none_set, e.yq, e.ov, e.ao, e.ns);
            end
        end
        n_checks++;
        if ({if1.y_q, if1.out_valid, if1.all_ones, if1.none_set} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset1: got yq=%b ov=%b ao=%b ns=%b, expected all 0",
                     if1.y_q, if1.out_valid, if1.all_ones, if1.none_set);
        end
        cycle8(8'h00, 8'h00, 1'b0, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_truth_table();
        logic [1:0] ab;
        logic       exp_y;
        for (int i = 0; i < 4; i++) begin
            ab    = 2'(i);
            if1.a = ab[1];
            if1.b = ab[0];
            exp_y = (i == 3) ? 1'b1 : 1'b0;
            #10;
            n_checks++;
            if (if1.y !== exp_y) begin
                n_fail++;
                $display("FAIL truth_%0d%0d: got y=%b, expected %b", ab[1], ab[0], if1.y, exp_y);
            end
        end
        if1.a = 1'b0;
        if1.b = 1'bx;
        #10;
        n_checks++;
        if (if1.y !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_and_x: got y=%b, expected 0", if1.y);
        end
        if1.b = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        @(negedge clk);
        if8.a = 8'hF0;
        if8.b = 8'h3C;
        #1;
        n_checks++;
        if (if8.y !== 8'h30) begin
            n_fail++;
            $display("FAIL comb_y: got y=%h, expected 30", if8.y);
        end
        cycle8(8'hF0, 8'h3C, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== {8'h30, 3'b100} ||
            {e.yq, e.ov, e.ao, e.ns} !== {8'h30, 3'b100}) begin
            n_fail++;
            $display("FAIL basic_capture: got yq=%h ov=%b ao=%b ns=%b, expected yq=30 ov=1 ao=0 ns=0",
                     if8.y_q, if8.out_valid, if8.all_ones, if8.none_set);
        end
        cycle8(8'h55, 8'hAA, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== {e.yq, e.ov, e.ao, e.ns}) begin
            n_fail++;
            $display("FAIL basic_hold: got yq=%h ov=%b ao=%b ns=%b, expected yq=%h ov=%b ao=%b ns=%b",
                     if8.y_q, if8.out_valid, if8.all_ones, if8.none_set, e.yq, e.ov, e.ao, e.ns);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] sa [3] = '{8'hFF, 8'hFF, 8'h12};
        logic [7:0] sb [3] = '{8'hFF, 8'h00, 8'h34};
        logic       sv [3] = '{1'b1, 1'b1, 1'b0};
        logic [10:0] req [3] = '{{8'hFF, 3'b110}, {8'h00, 3'b101}, {8'h00, 3'b000}};
        for (int i = 0; i < 3; i++) begin
            cycle8(sa[i], sb[i], sv[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== req[i] ||
                {e.yq, e.ov, e.ao, e.ns} !== req[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got yq=%h ov=%b ao=%b ns=%b, expected %h",
                         i, if8.y_q, if8.out_valid, if8.all_ones, if8.none_set, req[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        cycle8(8'hAA, 8'hFF, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        cycle8(8'hFF, 8'hFF, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== {e.yq, e.ov, e.ao, e.ns}) begin
            n_fail++;
            $display("FAIL reset_mid: got yq=%h ov=%b ao=%b ns=%b, expected yq=%h ov=%b ao=%b ns=%b",
                     if8.y_q, if8.out_valid, if8.all_ones, if8.none_set, e.yq, e.ov, e.ao, e.ns);
        end
        n_checks++;
        if (if8.y !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_comb_y: got y=%h, expected ff", if8.y);
        end
        cycle8(8'h00, 8'h00, 1'b0, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            cycle8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({if8.y_q, if8.out_valid, if8.all_ones, if8.none_set} !== {e.yq, e.ov, e.ao, e.ns}) begin
                n_fail++;
                $display("FAIL random_%0d: got yq=%h ov=%b ao=%b ns=%b, expected yq=%h ov=%b ao=%b ns=%b",
                         i, if8.y_q, if8.out_valid, if8.all_ones, if8.none_set, e.yq, e.ov, e.ao, e.ns);
            end
        end
    endtask

`ifdef AND_GATE_STATS_EN
    task automatic stat_cycle(input logic a0, input logic b0, input logic v,
                              input logic r, input logic clr);
        @(negedge clk);
        if8.a        = {7'h55, a0};
        if8.b        = {7'h2A, b0};
        if8.in_valid = v;
        rst          = r;
        if8.stat_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stats();
        logic [15:0] req [4] = '{16'd0, 16'd1, 16'd0, 16'd3};
        stat_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) stat_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        stat_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stat_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 3; s >= 0; s--) begin
            if8.stat_sel = 2'(s);
            #1;
            n_checks++;
            if (if8.stat_cnt !== req[s]) begin
                n_fail++;
                $display("FAIL stat_sel%0d: got cnt=%0d, expected %0d", s, if8.stat_cnt, req[s]);
            end
        end
        stat_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        stat_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            if8.stat_sel = 2'(s);
            #1;
            n_checks++;
            if (if8.stat_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL stat_clr%0d: got cnt=%0d, expected 0", s, if8.stat_cnt);
            end
        end
    endtask

    task automatic test_stats_sat();
        if8.stat_sel = 2'd0;
        stat_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65534; i++) stat_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if8.stat_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL stat_presat: got cnt=%h, expected fffe", if8.stat_cnt);
        end
        stat_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stat_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if8.stat_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stat_sat: got cnt=%h, expected ffff", if8.stat_cnt);
        end
        for (int i = 0; i < 5; i++) stat_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if8.stat_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stat_sat_hold: got cnt=%h, expected ffff", if8.stat_cnt);
        end
        stat_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        m_yq         = 8'h00;
        m_ov         = 1'b0;
        rst          = 1'b1;
        if1.a        = 1'b0;
        if1.b        = 1'b0;
        if1.in_valid = 1'b0;
        if8.a        = 8'h00;
        if8.b        = 8'h00;
        if8.in_valid = 1'b0;
`ifdef AND_GATE_STATS_EN
        if1.stat_clr = 1'b0;
        if1.stat_sel = 2'd0;
        if8.stat_clr = 1'b0;
        if8.stat_sel = 2'd0;
`endif
        test_reset();
        test_truth_table();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef AND_GATE_STATS_EN
        test_stats();
        test_stats_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
